vdp_cpu_bridge: RTL

Bridges the asynchronous Z80 I/O bus (A, rd_iorq_n, wr_iorq_n, cd) to the VDP CPU request interface (req/wrt/dbo/dbi/ack) in the pixel clock domain. It sits directly upstream of the VDP core in the top level. It synchronizes the strobes, decodes the VDP port window and runs one request/acknowledge transaction per bus cycle. It also returns read data for the top-level tristate driver on cd.

---
 rtl/vdp_cpu_bridge.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vdp_cpu_bridge.sv
// Z80 I/O bus to VDP CPU request bridge: synchronizes the async strobes,
// decodes the port window and runs one req/ack handshake per bus cycle.
module vdp_cpu_bridge #(
  parameter logic [7:0]  PORT_BASE   = 8'h98,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic       rd_iorq_n,
  input  logic       wr_iorq_n,
  input  logic [7:0] cd_in,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  output logic       cs_n,
  output logic       req,
  output logic       wrt,
  output logic [1:0] port,
  output logic [7:0] dbo,
  input  logic       ack,
  input  logic [7:0] dbi,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_DRIVE,
    S_RELEASE
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0]      r_rd_sync;
  logic [SYNC_STAGES-1:0]      r_wr_sync;
  logic [SYNC_STAGES-1:0][7:0] r_a_sync;
  logic [SYNC_STAGES-1:0][7:0] r_cd_sync;
  logic                        r_rd_prev;
  logic                        r_wr_prev;

  logic [7:0] r_cnt;
  logic [7:0] r_cd_out;
  logic       r_cd_oe;
  logic       r_cs_n;
  logic       r_req;
  logic       r_wrt;
  logic [1:0] r_port;
  logic [7:0] r_dbo;
  logic       r_timeout;

  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_a;
  logic [7:0] w_cd;
  logic       w_rd_fall;
  logic       w_wr_fall;
  logic       w_hit;
  logic       w_expired;

  assign w_rd      = r_rd_sync[SYNC_STAGES-1];
  assign w_wr      = r_wr_sync[SYNC_STAGES-1];
  assign w_a       = r_a_sync[SYNC_STAGES-1];
  assign w_cd      = r_cd_sync[SYNC_STAGES-1];
  assign w_rd_fall = ~w_rd & r_rd_prev;
  assign w_wr_fall = ~w_wr & r_wr_prev;
  assign w_hit     = (w_a[7:2] == PORT_BASE[7:2]);
  assign w_expired = (r_cnt == 8'(ACK_TIMEOUT - 1));

  // Strobe stages reset high so reset release cannot look like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_sync <= '1;
      r_wr_sync <= '1;
      r_a_sync  <= '0;
      r_cd_sync <= '0;
      r_rd_prev <= 1'b1;
      r_wr_prev <= 1'b1;
    end else begin
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], rd_iorq_n};
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], wr_iorq_n};
      r_a_sync  <= {r_a_sync[SYNC_STAGES-2:0], A};
      r_cd_sync <= {r_cd_sync[SYNC_STAGES-2:0], cd_in};
      r_rd_prev <= w_rd;
      r_wr_prev <= w_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cd_out  <= '0;
      r_cd_oe   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_req     <= 1'b0;
      r_wrt     <= 1'b0;
      r_port    <= '0;
      r_dbo     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit && w_rd_fall && w_wr_fall) begin
            r_state <= S_RELEASE;
            r_cs_n  <= 1'b0;
          end else if (w_hit && w_wr_fall && w_rd) begin
            r_state <= S_WR_REQ;
            r_cs_n  <= 1'b0;
            r_req   <= 1'b1;
            r_wrt   <= 1'b1;
            r_port  <= w_a[1:0];
            r_dbo   <= w_cd;
            r_cnt   <= '0;
          end else if (w_hit && w_rd_fall && w_wr) begin
            r_state <= S_RD_REQ;
            r_cs_n  <= 1'b0;
            r_req   <= 1'b1;
            r_wrt   <= 1'b0;
            r_port  <= w_a[1:0];
            r_cnt   <= '0;
          end
        end
        S_WR_REQ: begin
          if (ack || w_expired) begin
            r_req     <= 1'b0;
            r_timeout <= ~ack;
            r_state   <= S_RELEASE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RD_REQ: begin
          if (ack || w_expired) begin
            r_req     <= 1'b0;
            r_timeout <= ~ack;
            r_cd_out  <= ack ? dbi : 8'hFF;
            // A read whose strobe already went away skips the drive phase.
            if (!w_rd) begin
              r_cd_oe <= 1'b1;
              r_state <= S_RD_DRIVE;
            end else begin
              r_cs_n  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RD_DRIVE: begin
          if (w_rd) begin
            r_cd_oe <= 1'b0;
            r_cs_n  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (w_rd && w_wr) begin
            r_cs_n  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_cd_oe <= 1'b0;
          r_cs_n  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cd_out  = r_cd_out;
  assign cd_oe   = r_cd_oe;
  assign cs_n    = r_cs_n;
  assign req     = r_req;
  assign wrt     = r_wrt;
  assign port    = r_port;
  assign dbo     = r_dbo;
  assign timeout = r_timeout;

endmodule
